// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: valid/ready byte in, LSB-first frame out, paced by txclk rising edges.
// Optional parity bit when UART_TX_PARITY_EN is defined (PARITY_ODD selects odd/even sense).
module uart_tx_serializer #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 txclk,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARMED  = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif
  localparam logic [2:0] S_STOP   = 3'd5;

  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
      $error("uart_tx_serializer: unsupported parameter set");
    end
  endgenerate

`ifdef UART_TX_PARITY_EN
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (PARITY_ODD == 1) ? ~^d : ^d;
  endfunction
`endif

  logic [2:0]           state;
  logic                 txclk_d;
  logic                 tick;
  logic [DATA_BITS-1:0] shift;
  logic [3:0]           bitcnt;
  logic                 stopcnt;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  assign tick     = txclk & ~txclk_d;
  assign tx_ready = (state == S_IDLE);
  assign tx_busy  = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      txclk_d    <= 1'b0;
      state      <= S_IDLE;
      tx         <= 1'b1;
      tx_done    <= 1'b0;
      shift      <= '0;
      bitcnt     <= '0;
      stopcnt    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      txclk_d <= txclk;
      tx_done <= 1'b0;
      case (state)
        // A tick coinciding with acceptance is deliberately skipped: ARMED waits for the next one.
        S_IDLE: begin
          if (tx_valid) begin
            shift      <= tx_data;
`ifdef UART_TX_PARITY_EN
            parity_bit <= parity_of(tx_data);
`endif
            state      <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (tick) begin
            tx    <= 1'b0;
            state <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            tx     <= shift[0];
            shift  <= shift >> 1;
            bitcnt <= '0;
            state  <= S_DATA;
          end
        end
        S_DATA: begin
          if (tick) begin
            if (bitcnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              tx      <= parity_bit;
              state   <= S_PARITY;
`else
              tx      <= 1'b1;
              stopcnt <= 1'b0;
              state   <= S_STOP;
`endif
            end else begin
              tx     <= shift[0];
              shift  <= shift >> 1;
              bitcnt <= bitcnt + 4'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            tx      <= 1'b1;
            stopcnt <= 1'b0;
            state   <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (tick) begin
            if (stopcnt == LAST_STOP) begin
              tx_done <= 1'b1;
              state   <= S_IDLE;
            end else begin
              stopcnt <= stopcnt + 1'b1;
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: one instance with 1 stop bit (even parity), one with 2 (odd parity).
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic txclk = 1'b0;
  logic [7:0] data_a = 8'h00, data_b = 8'h00;
  logic valid_a = 1'b0, valid_b = 1'b0;
  logic ready_a, tx_a, busy_a, done_a;
  logic ready_b, tx_b, busy_b, done_b;

  int errors = 0;
  int checks = 0;
  bit sel = 1'b0;
  logic tx_m, done_m, ready_m, busy_m;
  logic [3:0] cap [0:255];

  assign tx_m    = sel ? tx_b    : tx_a;
  assign done_m  = sel ? done_b  : done_a;
  assign ready_m = sel ? ready_b : ready_a;
  assign busy_m  = sel ? busy_b  : busy_a;

  uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
    .clk(clk), .rst(rst), .txclk(txclk), .tx_data(data_a), .tx_valid(valid_a),
    .tx_ready(ready_a), .tx(tx_a), .tx_busy(busy_a), .tx_done(done_a));

  uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(1)) dut_b (
    .clk(clk), .rst(rst), .txclk(txclk), .tx_data(data_b), .tx_valid(valid_b),
    .tx_ready(ready_b), .tx(tx_b), .tx_busy(busy_b), .tx_done(done_b));

  always #5 clk = ~clk;

  // txclk toggles every 4 clk, 2 ns after a falling clk edge; ticks every 8 clk
  initial begin
    #12;
    forever #40 txclk = ~txclk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Expected {tx, tx_done, tx_ready, tx_busy} n falling edges after the start bit appears.
  function automatic logic [3:0] exp_word(input logic [7:0] d, input int n, input int nstop,
                                          input logic par);
    int b;
    int len;
    logic bv;
    b = n / 8;
    len = 9 + PB + nstop;
    if (n >= 8 * len) return 4'b1110;
    if (b == 0) bv = 1'b0;
    else if (b <= 8) bv = d[b-1];
    else if (PB == 1 && b == 9) bv = par;
    else bv = 1'b1;
    return {bv, 3'b001};
  endfunction

  task automatic send(input bit which, input logic [7:0] d);
    int w;
    w = 0;
    if (which) begin data_b = d; valid_b = 1'b1; end
    else begin data_a = d; valid_a = 1'b1; end
    while (!(which ? ready_b : ready_a) && w < 200) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (w >= 200) begin
      errors++;
      $display("FAIL send_ready_timeout got=%0d cycles required<200", w);
    end
    @(negedge clk);
    if (which) valid_b = 1'b0; else valid_a = 1'b0;
  endtask

  task automatic capture(input int ncyc);
    int w;
    w = 0;
    while (tx_m !== 1'b0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (w >= 300) begin
      errors++;
      $display("FAIL start_bit_timeout got=%0d cycles required<300", w);
    end
    for (int n = 0; n < ncyc; n++) begin
      if (n > 0) @(negedge clk);
      cap[n] = {tx_m, done_m, ready_m, busy_m};
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_a, done_a, ready_a, busy_a} !== 4'b1010) begin
      errors++;
      $display("FAIL reset_a got=%b required=1010", {tx_a, done_a, ready_a, busy_a});
    end
    checks++;
    if ({tx_b, done_b, ready_b, busy_b} !== 4'b1010) begin
      errors++;
      $display("FAIL reset_b got=%b required=1010", {tx_b, done_b, ready_b, busy_b});
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    int len;
    len = 10 + PB;
    sel = 1'b0;
    send(1'b0, 8'h55);
    capture(8 * len + 2);
    for (int n = 0; n <= 8 * len; n++) begin
      checks++;
      if (cap[n] !== exp_word(8'h55, n, 1, 1'b0)) begin
        errors++;
        $display("FAIL basic_55 n=%0d got=%b required=%b", n, cap[n], exp_word(8'h55, n, 1, 1'b0));
      end
    end
    checks++;
    if (cap[8 * len + 1][2] !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_width got=%b required=0", cap[8 * len + 1][2]);
    end
  endtask

  task automatic test_parity();
    int len;
    len = 10 + PB;
    sel = 1'b0;
    send(1'b0, 8'hA5);
    capture(8 * len + 1);
    for (int n = 0; n <= 8 * len; n++) begin
      checks++;
      if (cap[n] !== exp_word(8'hA5, n, 1, 1'b0)) begin
        errors++;
        $display("FAIL parity_even_A5 n=%0d got=%b required=%b", n, cap[n], exp_word(8'hA5, n, 1, 1'b0));
      end
    end
    len = 11 + PB;
    sel = 1'b1;
    send(1'b1, 8'hA5);
    capture(8 * len + 1);
    for (int n = 0; n <= 8 * len; n++) begin
      checks++;
      if (cap[n] !== exp_word(8'hA5, n, 2, 1'b1)) begin
        errors++;
        $display("FAIL parity_odd_A5 n=%0d got=%b required=%b", n, cap[n], exp_word(8'hA5, n, 2, 1'b1));
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_two_stop();
    int len;
    len = 11 + PB;
    sel = 1'b1;
    send(1'b1, 8'h00);
    capture(8 * len + 2);
    for (int n = 0; n <= 8 * len; n++) begin
      checks++;
      if (cap[n] !== exp_word(8'h00, n, 2, 1'b1)) begin
        errors++;
        $display("FAIL two_stop_00 n=%0d got=%b required=%b", n, cap[n], exp_word(8'h00, n, 2, 1'b1));
      end
    end
    checks++;
    if (cap[8 * len + 1][2] !== 1'b0) begin
      errors++;
      $display("FAIL two_stop_done_width got=%b required=0", cap[8 * len + 1][2]);
    end
    sel = 1'b0;
  endtask

  task automatic test_backpressure();
    int len;
    len = 10 + PB;
    sel = 1'b0;
    send(1'b0, 8'h81);
    data_a = 8'h3C;
    valid_a = 1'b1;
    capture(8 * len + 2);
    for (int n = 0; n <= 8 * len; n++) begin
      checks++;
      if (cap[n] !== exp_word(8'h81, n, 1, 1'b0)) begin
        errors++;
        $display("FAIL backpressure_81 n=%0d got=%b required=%b", n, cap[n], exp_word(8'h81, n, 1, 1'b0));
      end
    end
    // held byte must have been taken right after the done cycle
    checks++;
    if (cap[8 * len + 1] !== 4'b1001) begin
      errors++;
      $display("FAIL backpressure_accept got=%b required=1001", cap[8 * len + 1]);
    end
    valid_a = 1'b0;
    capture(8 * len + 1);
    for (int n = 0; n <= 8 * len; n++) begin
      checks++;
      if (cap[n] !== exp_word(8'h3C, n, 1, 1'b0)) begin
        errors++;
        $display("FAIL backpressure_3C n=%0d got=%b required=%b", n, cap[n], exp_word(8'h3C, n, 1, 1'b0));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int len;
    int w;
    int bad;
    len = 10 + PB;
    sel = 1'b0;
    send(1'b0, 8'hF0);
    w = 0;
    while (tx_a !== 1'b0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (w >= 300) begin
      errors++;
      $display("FAIL reset_mid_start_timeout got=%0d required<300", w);
    end
    repeat (36) @(negedge clk);
    checks++;
    if (tx_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_bit3 got=%b required=0", tx_a);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({tx_a, done_a, ready_a, busy_a} !== 4'b1010) begin
      errors++;
      $display("FAIL reset_mid_state got=%b required=1010", {tx_a, done_a, ready_a, busy_a});
    end
    bad = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (done_a !== 1'b0 || tx_a !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet got=%0d bad cycles required=0", bad);
    end
    send(1'b0, 8'hA3);
    capture(8 * len + 1);
    for (int n = 0; n <= 8 * len; n++) begin
      checks++;
      if (cap[n] !== exp_word(8'hA3, n, 1, 1'b0)) begin
        errors++;
        $display("FAIL reset_mid_next_A3 n=%0d got=%b required=%b", n, cap[n], exp_word(8'hA3, n, 1, 1'b0));
      end
    end
  endtask

  task automatic test_tick_handshake();
    int len;
    len = 10 + PB;
    sel = 1'b0;
    repeat (10) @(negedge clk);
    @(posedge txclk);
    data_a = 8'h96;
    valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    checks++;
    if ({tx_a, ready_a, busy_a} !== 3'b101) begin
      errors++;
      $display("FAIL tick_hs_accept got=%b required=101", {tx_a, ready_a, busy_a});
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (tx_a !== (k == 8 ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL tick_hs_start k=%0d got=%b required=%b", k, tx_a, (k == 8 ? 1'b0 : 1'b1));
      end
    end
    capture(8 * len + 1);
    for (int n = 0; n <= 8 * len; n++) begin
      checks++;
      if (cap[n] !== exp_word(8'h96, n, 1, 1'b0)) begin
        errors++;
        $display("FAIL tick_hs_96 n=%0d got=%b required=%b", n, cap[n], exp_word(8'h96, n, 1, 1'b0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_two_stop();
    test_backpressure();
    test_reset_mid_frame();
    test_tick_handshake();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
